// File: rtl/gpu_draw_sequencer_pkg.sv
// Shared widths, opcodes, FSM encoding and the instruction payload for the draw sequencer.
package gpu_draw_sequencer_pkg;

   localparam int unsigned WIDTH_BITS   = 10;
   localparam int unsigned HEIGHT_BITS  = 10;
   localparam int unsigned CHANNEL_BITS = 8;
   localparam int unsigned OPCODE_BITS  = 4;

   localparam logic [OPCODE_BITS-1:0] OP_PIXEL = 4'h1;
   localparam logic [OPCODE_BITS-1:0] OP_RECT  = 4'h2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [OPCODE_BITS-1:0]  opcode;
      logic [WIDTH_BITS-1:0]   x1;
      logic [HEIGHT_BITS-1:0]  y1;
      logic [WIDTH_BITS-1:0]   x2;
      logic [HEIGHT_BITS-1:0]  y2;
      logic [CHANNEL_BITS-1:0] r;
      logic [CHANNEL_BITS-1:0] g;
      logic [CHANNEL_BITS-1:0] b;
   } instr_t;

   // Opcodes that produce pixels; everything else is popped and dropped.
   function automatic logic is_drawable(input logic [OPCODE_BITS-1:0] op);
      return (op == OP_PIXEL) || (op == OP_RECT);
   endfunction

endpackage

// File: rtl/gpu_draw_sequencer_if.sv
// Instruction push bus, status flags and pixel valid/ready stream of the draw sequencer.
interface gpu_draw_sequencer_if;
   import gpu_draw_sequencer_pkg::*;

   logic                    push_i;
   logic [OPCODE_BITS-1:0]  opcode_i;
   logic [WIDTH_BITS-1:0]   x1_i;
   logic [WIDTH_BITS-1:0]   x2_i;
   logic [HEIGHT_BITS-1:0]  y1_i;
   logic [HEIGHT_BITS-1:0]  y2_i;
   logic [CHANNEL_BITS-1:0] r_i;
   logic [CHANNEL_BITS-1:0] g_i;
   logic [CHANNEL_BITS-1:0] b_i;
   logic                    full_o;
   logic                    overflow_o;
   logic                    busy_o;
   logic                    done_o;
   logic                    pix_valid_o;
   logic                    pix_ready_i;
   logic [WIDTH_BITS-1:0]   x_o;
   logic [HEIGHT_BITS-1:0]  y_o;
   logic [CHANNEL_BITS-1:0] r_o;
   logic [CHANNEL_BITS-1:0] g_o;
   logic [CHANNEL_BITS-1:0] b_o;

   modport master (
      output push_i, opcode_i, x1_i, x2_i, y1_i, y2_i, r_i, g_i, b_i, pix_ready_i,
      input  full_o, overflow_o, busy_o, done_o, pix_valid_o, x_o, y_o, r_o, g_o, b_o
   );

   modport slave (
      input  push_i, opcode_i, x1_i, x2_i, y1_i, y2_i, r_i, g_i, b_i, pix_ready_i,
      output full_o, overflow_o, busy_o, done_o, pix_valid_o, x_o, y_o, r_o, g_o, b_o
   );

endinterface

// File: rtl/gpu_draw_sequencer_instr_fifo.sv
// Synchronous instruction FIFO with registered full/empty flags.
module gpu_instr_fifo
   import gpu_draw_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic   clk,
   input  logic   n_rst,
   input  logic   push,
   input  instr_t push_data,
   input  logic   pop,
   output instr_t head,
   output logic   full,
   output logic   empty,
   output logic   empty_nxt_c
);

   localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_BITS = PTR_BITS + 1;

   instr_t              mem [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic [CNT_BITS-1:0] count;
   logic [CNT_BITS-1:0] count_nxt;
   logic                push_ok;
   logic                pop_ok;

   // A push while full is dropped even if a pop frees a slot on the same edge.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok) begin
         count_nxt = count + CNT_BITS'(1);
      end else if (pop_ok && !push_ok) begin
         count_nxt = count - CNT_BITS'(1);
      end
   end

   assign empty_nxt_c = (count_nxt == '0);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         count <= count_nxt;
         full  <= (count_nxt == CNT_BITS'(DEPTH));
         empty <= empty_nxt_c;
      end
   end

   // Storage needs no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/gpu_draw_sequencer.sv
// Pops drawing instructions from a FIFO and walks each primitive in raster order
// onto a valid/ready pixel stream.
module gpu_draw_sequencer
   import gpu_draw_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                  clk,
   input logic                  n_rst,
   gpu_draw_sequencer_if.slave  bus
);

   instr_t                  push_data;
   instr_t                  head;
   instr_t                  work_q;
   instr_t                  work_d;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_empty_nxt;
   logic                    pop;

   state_t                  state_q;
   state_t                  state_d;

   logic [WIDTH_BITS-1:0]   lo_x;
   logic [WIDTH_BITS-1:0]   hi_x;
   logic [HEIGHT_BITS-1:0]  lo_y;
   logic [HEIGHT_BITS-1:0]  hi_y;

   logic [WIDTH_BITS-1:0]   xmin_q;
   logic [WIDTH_BITS-1:0]   xmin_d;
   logic [WIDTH_BITS-1:0]   xmax_q;
   logic [WIDTH_BITS-1:0]   xmax_d;
   logic [HEIGHT_BITS-1:0]  ymax_q;
   logic [HEIGHT_BITS-1:0]  ymax_d;
   logic [WIDTH_BITS-1:0]   cur_x_q;
   logic [WIDTH_BITS-1:0]   cur_x_d;
   logic [HEIGHT_BITS-1:0]  cur_y_q;
   logic [HEIGHT_BITS-1:0]  cur_y_d;
   logic [CHANNEL_BITS-1:0] r_q;
   logic [CHANNEL_BITS-1:0] r_d;
   logic [CHANNEL_BITS-1:0] g_q;
   logic [CHANNEL_BITS-1:0] g_d;
   logic [CHANNEL_BITS-1:0] b_q;
   logic [CHANNEL_BITS-1:0] b_d;

   logic                    valid_q;
   logic                    valid_d;
   logic                    done_q;
   logic                    done_d;
   logic                    busy_q;
   logic                    busy_d;
   logic                    ovf_q;
   logic                    ovf_d;

   assign push_data = '{
      opcode: bus.opcode_i,
      x1:     bus.x1_i,
      y1:     bus.y1_i,
      x2:     bus.x2_i,
      y2:     bus.y2_i,
      r:      bus.r_i,
      g:      bus.g_i,
      b:      bus.b_i
   };

   gpu_instr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .n_rst       (n_rst),
      .push        (bus.push_i),
      .push_data   (push_data),
      .pop         (pop),
      .head        (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .empty_nxt_c (fifo_empty_nxt)
   );

   // Bound normalisation; a single pixel uses (x1, y1) for both corners.
   always_comb begin
      lo_x = work_q.x1;
      hi_x = work_q.x1;
      lo_y = work_q.y1;
      hi_y = work_q.y1;
      if (work_q.opcode == OP_RECT) begin
         if (work_q.x2 < work_q.x1) begin
            lo_x = work_q.x2;
         end else begin
            hi_x = work_q.x2;
         end
         if (work_q.y2 < work_q.y1) begin
            lo_y = work_q.y2;
         end else begin
            hi_y = work_q.y2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus next values of every registered output and walk counter.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      work_d  = work_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymax_d  = ymax_q;
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               work_d  = head;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (is_drawable(work_q.opcode)) begin
               xmin_d  = lo_x;
               xmax_d  = hi_x;
               ymax_d  = hi_y;
               cur_x_d = lo_x;
               cur_y_d = lo_y;
               r_d     = work_q.r;
               g_d     = work_q.g;
               b_d     = work_q.b;
               state_d = ST_EMIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (bus.pix_ready_i) begin
               if (cur_x_q < xmax_q) begin
                  cur_x_d = cur_x_q + WIDTH_BITS'(1);
               end else if (cur_y_q < ymax_q) begin
                  cur_x_d = xmin_q;
                  cur_y_d = cur_y_q + HEIGHT_BITS'(1);
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      valid_d = (state_d == ST_EMIT);
      busy_d  = (state_d != ST_IDLE) || !fifo_empty_nxt;
      ovf_d   = ovf_q || (bus.push_i && fifo_full);
   end

   // Pixel outputs are the walk counters, so they only move on load or handshake.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         work_q  <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         cur_x_q <= '0;
         cur_y_q <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         work_q  <= work_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymax_q  <= ymax_d;
         cur_x_q <= cur_x_d;
         cur_y_q <= cur_y_d;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.full_o      = fifo_full;
   assign bus.overflow_o  = ovf_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.pix_valid_o = valid_q;
   assign bus.x_o         = cur_x_q;
   assign bus.y_o         = cur_y_q;
   assign bus.r_o         = r_q;
   assign bus.g_o         = g_q;
   assign bus.b_o         = b_q;

endmodule

// File: tb/tb_gpu_draw_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_gpu_draw_sequencer;
   import gpu_draw_sequencer_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int MAX_X = (1 << WIDTH_BITS) - 1;
   localparam int MAX_Y = (1 << HEIGHT_BITS) - 1;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   gpu_draw_sequencer_if bus();

   gpu_draw_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   typedef struct { int op; int x1; int y1; int x2; int y2; int r; int g; int b; } m_instr_t;

   // Model: pending instructions, the job being worked on, and its remaining pixels.
   m_instr_t m_q[$];
   m_instr_t m_job;
   int       m_px[$];
   int       m_py[$];
   int       m_phase;   // 0 idle, 1 loading, 2 emitting
   bit       m_valid, m_done, m_ovf;
   int       m_x, m_y, m_r, m_g, m_b;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int gx[16];
   int gy[16];
   int n, dones, hs, hit, first_hs, second_valid, bad;
   int pat[4];

   task automatic model_reset();
      m_q.delete();
      m_px.delete();
      m_py.delete();
      m_phase = 0;
      m_valid = 0;
      m_done  = 0;
      m_ovf   = 0;
      m_x = 0; m_y = 0; m_r = 0; m_g = 0; m_b = 0;
   endtask

   task automatic model_step();
      bit       push_ok;
      m_instr_t ni;
      int       xa, xb, ya, yb;
      if (!n_rst) begin
         model_reset();
         return;
      end
      push_ok = bus.push_i && (m_q.size() < DEPTH);
      if (bus.push_i && !push_ok) m_ovf = 1;
      m_done = 0;
      case (m_phase)
         0: begin
            if (m_q.size() != 0) begin
               m_job   = m_q.pop_front();
               m_phase = 1;
            end
         end
         1: begin
            if (m_job.op == int'(OP_PIXEL) || m_job.op == int'(OP_RECT)) begin
               if (m_job.op == int'(OP_PIXEL)) begin
                  xa = m_job.x1; xb = m_job.x1; ya = m_job.y1; yb = m_job.y1;
               end else begin
                  xa = (m_job.x1 < m_job.x2) ? m_job.x1 : m_job.x2;
                  xb = (m_job.x1 < m_job.x2) ? m_job.x2 : m_job.x1;
                  ya = (m_job.y1 < m_job.y2) ? m_job.y1 : m_job.y2;
                  yb = (m_job.y1 < m_job.y2) ? m_job.y2 : m_job.y1;
               end
               m_px.delete();
               m_py.delete();
               for (int yy = ya; yy <= yb; yy++) begin
                  for (int xx = xa; xx <= xb; xx++) begin
                     m_px.push_back(xx);
                     m_py.push_back(yy);
                  end
               end
               m_valid = 1;
               m_x = m_px[0]; m_y = m_py[0];
               m_r = m_job.r; m_g = m_job.g; m_b = m_job.b;
               m_phase = 2;
            end else begin
               m_phase = 0;
            end
         end
         default: begin
            if (bus.pix_ready_i) begin
               void'(m_px.pop_front());
               void'(m_py.pop_front());
               if (m_px.size() != 0) begin
                  m_x = m_px[0];
                  m_y = m_py[0];
               end else begin
                  m_valid = 0;
                  m_done  = 1;
                  m_phase = 0;
               end
            end
         end
      endcase
      if (push_ok) begin
         ni.op = int'(bus.opcode_i);
         ni.x1 = int'(bus.x1_i); ni.y1 = int'(bus.y1_i);
         ni.x2 = int'(bus.x2_i); ni.y2 = int'(bus.y2_i);
         ni.r  = int'(bus.r_i);  ni.g  = int'(bus.g_i);  ni.b = int'(bus.b_i);
         m_q.push_back(ni);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   task automatic cycle_check();
      bit busy_e;
      bit full_e;
      busy_e = (m_q.size() != 0) || (m_phase != 0);
      full_e = (m_q.size() == DEPTH);
      checks++;
      if (bus.pix_valid_o !== m_valid || bus.done_o !== m_done || bus.busy_o !== busy_e ||
          bus.full_o !== full_e || bus.overflow_o !== m_ovf ||
          int'(bus.x_o) != m_x || int'(bus.y_o) != m_y ||
          int'(bus.r_o) != m_r || int'(bus.g_o) != m_g || int'(bus.b_o) != m_b) begin
         errors++;
         if (errors <= 30)
            $display("FAIL cycle %0d: got v=%0b d=%0b busy=%0b full=%0b ovf=%0b x=%0d y=%0d rgb=%0d/%0d/%0d, required v=%0b d=%0b busy=%0b full=%0b ovf=%0b x=%0d y=%0d rgb=%0d/%0d/%0d",
                     cyc, bus.pix_valid_o, bus.done_o, bus.busy_o, bus.full_o, bus.overflow_o,
                     bus.x_o, bus.y_o, bus.r_o, bus.g_o, bus.b_o,
                     m_valid, m_done, busy_e, full_e, m_ovf, m_x, m_y, m_r, m_g, m_b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cycle_check();
      cyc++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic set_push(input int op, input int x1, input int y1, input int x2, input int y2,
                           input int r, input int g, input int b);
      bus.push_i   = 1'b1;
      bus.opcode_i = OPCODE_BITS'(op);
      bus.x1_i     = WIDTH_BITS'(x1);
      bus.y1_i     = HEIGHT_BITS'(y1);
      bus.x2_i     = WIDTH_BITS'(x2);
      bus.y2_i     = HEIGHT_BITS'(y2);
      bus.r_i      = CHANNEL_BITS'(r);
      bus.g_i      = CHANNEL_BITS'(g);
      bus.b_i      = CHANNEL_BITS'(b);
   endtask

   task automatic clr_push();
      bus.push_i = 1'b0;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      clr_push();
      bus.pix_ready_i = 1'b0;
      tick();
      tick();
      check("reset_valid", int'(bus.pix_valid_o), 0);
      check("reset_done",  int'(bus.done_o), 0);
      check("reset_busy",  int'(bus.busy_o), 0);
      check("reset_full",  int'(bus.full_o), 0);
      check("reset_ovf",   int'(bus.overflow_o), 0);
      check("reset_xy",    int'(bus.x_o) + int'(bus.y_o), 0);
      n_rst = 1'b1;
   endtask

   function automatic int rnd_base(input int maxv);
      if ($urandom_range(0, 4) == 0) return maxv - int'($urandom_range(0, 1));
      return int'($urandom_range(0, maxv));
   endfunction

   function automatic int rnd_near(input int base, input int maxv);
      int v;
      v = base + int'($urandom_range(0, 6)) - 3;
      if (v < 0) v = 0;
      if (v > maxv) v = maxv;
      return v;
   endfunction

   initial begin
      int op, bx, by;
      n_rst = 1'b0;
      bus.push_i = 1'b0;
      bus.opcode_i = '0;
      bus.x1_i = '0; bus.y1_i = '0; bus.x2_i = '0; bus.y2_i = '0;
      bus.r_i = '0; bus.g_i = '0; bus.b_i = '0;
      bus.pix_ready_i = 1'b0;
      model_reset();
      pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;

      // Single pixel latency and done timing.
      do_reset();
      bus.pix_ready_i = 1'b1;
      set_push(int'(OP_PIXEL), 5, 7, 0, 0, 'h1F, 0, 0);
      tick();
      clr_push();
      check("px_e0_valid", int'(bus.pix_valid_o), 0);
      tick();
      check("px_e1_valid", int'(bus.pix_valid_o), 0);
      tick();
      check("px_e2_valid", int'(bus.pix_valid_o), 1);
      check("px_e2_x", int'(bus.x_o), 5);
      check("px_e2_y", int'(bus.y_o), 7);
      check("px_e2_r", int'(bus.r_o), 31);
      tick();
      check("px_e3_done", int'(bus.done_o), 1);
      check("px_e3_valid", int'(bus.pix_valid_o), 0);
      check("px_e3_busy", int'(bus.busy_o), 0);
      tick();
      check("px_e4_done", int'(bus.done_o), 0);

      // Swapped rectangle corners.
      set_push(int'(OP_RECT), 3, 2, 1, 1, 10, 20, 30);
      tick();
      clr_push();
      n = 0; dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.pix_valid_o && bus.pix_ready_i) begin
            if (n < 16) begin gx[n] = int'(bus.x_o); gy[n] = int'(bus.y_o); end
            n++;
         end
         if (bus.done_o) dones++;
         tick();
      end
      check("rect_count", n, 6);
      check("rect_dones", dones, 1);
      check("rect_p0", gx[0] * 100 + gy[0], 101);
      check("rect_p1", gx[1] * 100 + gy[1], 201);
      check("rect_p2", gx[2] * 100 + gy[2], 301);
      check("rect_p3", gx[3] * 100 + gy[3], 102);
      check("rect_p4", gx[4] * 100 + gy[4], 202);
      check("rect_p5", gx[5] * 100 + gy[5], 302);

      // Backpressure on a 2x2 rectangle.
      bus.pix_ready_i = 1'b0;
      set_push(int'(OP_RECT), 4, 6, 5, 7, 1, 2, 3);
      tick();
      clr_push();
      n = 0; dones = 0;
      for (int i = 0; i < 40; i++) begin
         bus.pix_ready_i = pat[i % 4][0];
         if (bus.pix_valid_o && bus.pix_ready_i) begin
            if (n < 16) begin gx[n] = int'(bus.x_o); gy[n] = int'(bus.y_o); end
            n++;
         end
         if (bus.done_o) dones++;
         tick();
      end
      check("bp_count", n, 4);
      check("bp_dones", dones, 1);
      check("bp_p0", gx[0] * 100 + gy[0], 406);
      check("bp_p1", gx[1] * 100 + gy[1], 506);
      check("bp_p2", gx[2] * 100 + gy[2], 407);
      check("bp_p3", gx[3] * 100 + gy[3], 507);

      // FIFO fill and overflow with the sink stalled.
      bus.pix_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_push(int'(OP_PIXEL), i, 2 * i, 0, 0, i + 1, 0, 0);
         tick();
      end
      clr_push();
      check("fifo_full", int'(bus.full_o), 1);
      check("fifo_ovf", int'(bus.overflow_o), 1);
      check("fifo_first_valid", int'(bus.pix_valid_o), 1);
      check("fifo_first_x", int'(bus.x_o), 0);
      bus.pix_ready_i = 1'b1;
      n = 0; dones = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.pix_valid_o && bus.pix_ready_i) begin
            if (n < 16) gx[n] = int'(bus.x_o);
            n++;
         end
         if (bus.done_o) dones++;
         tick();
      end
      check("fifo_dones", dones, 5);
      check("fifo_count", n, 5);
      for (int i = 0; i < 5; i++) check($sformatf("fifo_x%0d", i), gx[i], i);
      check("fifo_ovf_sticky", int'(bus.overflow_o), 1);

      // Unknown opcode followed by back-to-back pixels; reset also clears overflow.
      do_reset();
      bus.pix_ready_i = 1'b1;
      set_push(15, 7, 7, 7, 7, 1, 1, 1);
      tick();
      set_push(int'(OP_PIXEL), 0, 0, 0, 0, 2, 2, 2);
      tick();
      set_push(int'(OP_PIXEL), 9, 9, 0, 0, 3, 3, 3);
      tick();
      clr_push();
      n = 0; dones = 0; first_hs = -1; second_valid = -1;
      for (int i = 0; i < 20; i++) begin
         if (bus.pix_valid_o) begin
            if (n == 0) first_hs = i;
            if (n == 1 && second_valid < 0) second_valid = i;
            if (n < 16) begin gx[n] = int'(bus.x_o); gy[n] = int'(bus.y_o); end
            n++;
         end
         if (bus.done_o) dones++;
         tick();
      end
      check("unk_count", n, 2);
      check("unk_dones", dones, 2);
      check("unk_p0", gx[0] * 100 + gy[0], 0);
      check("unk_p1", gx[1] * 100 + gy[1], 909);
      check("unk_gap", second_valid - first_hs - 1, 2);

      // Reset while the fifth pixel of a 4x4 rectangle is on the bus.
      set_push(int'(OP_RECT), 0, 0, 3, 3, 5, 5, 5);
      tick();
      set_push(int'(OP_PIXEL), 8, 8, 0, 0, 6, 6, 6);
      tick();
      clr_push();
      hs = 0; hit = 0;
      for (int i = 0; i < 40 && hit == 0; i++) begin
         if (bus.pix_valid_o) begin
            if (hs == 4) hit = 1;
            else hs++;
         end
         if (hit == 0) tick();
      end
      check("mid_reached", hit, 1);
      check("mid_pixel", int'(bus.x_o) * 100 + int'(bus.y_o), 1);
      n_rst = 1'b0;
      tick();
      check("mid_valid", int'(bus.pix_valid_o), 0);
      check("mid_done", int'(bus.done_o), 0);
      check("mid_busy", int'(bus.busy_o), 0);
      check("mid_xy", int'(bus.x_o) + int'(bus.y_o), 0);
      check("mid_rgb", int'(bus.r_o) + int'(bus.g_o) + int'(bus.b_o), 0);
      n_rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.pix_valid_o || bus.done_o || bus.busy_o) bad++;
      end
      check("mid_flushed", bad, 0);

      // Random traffic, including coordinates at the top of the range.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         bus.pix_ready_i = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) < 3) begin
            op = int'($urandom_range(0, 9));
            op = (op < 4) ? int'(OP_PIXEL) : (op < 8) ? int'(OP_RECT) : int'($urandom_range(0, 15));
            bx = rnd_base(MAX_X);
            by = rnd_base(MAX_Y);
            set_push(op, bx, by, rnd_near(bx, MAX_X), rnd_near(by, MAX_Y),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)));
         end else begin
            clr_push();
         end
         tick();
      end
      clr_push();
      bus.pix_ready_i = 1'b1;
      for (int i = 0; i < 2000 && (m_q.size() != 0 || m_phase != 0 || m_done); i++) tick();
      tick();
      check("drain_busy", int'(bus.busy_o), 0);
      check("drain_valid", int'(bus.pix_valid_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpu_draw_sequencer.md
# gpu_draw_sequencer

Sequences decoded drawing instructions into a raster pixel stream. Sits between `gpu_instruction_decoder` (push side) and the frame-buffer write port (pixel side). Buffers instructions in a small FIFO, walks each primitive's pixel coordinates in raster order, and throttles on frame-buffer backpressure with a valid/ready handshake.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: instruction FIFO entries; power of two, ≥ 2.
- Coordinate and channel widths come from `WIDTH_BITS`, `HEIGHT_BITS` and `CHANNEL_BITS` in `gpu_definitions.vh`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, synchronous, active-low.
- `push_i`  in  1  enqueue the instruction on the `*_i` buses this cycle.
- `opcode_i`  in  4  instruction opcode.
- `x1_i`, `x2_i`  in  `WIDTH_BITS`  corner x coordinates.
- `y1_i`, `y2_i`  in  `HEIGHT_BITS`  corner y coordinates.
- `r_i`, `g_i`, `b_i`  in  `CHANNEL_BITS`  colour.
- `full_o`  out  1  FIFO full.
- `overflow_o`  out  1  sticky: set when a push is dropped.
- `busy_o`  out  1  FIFO non-empty or state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse when an instruction finishes.
- `pix_valid_o`  out  1  pixel on `x_o`/`y_o`/`r_o`/`g_o`/`b_o` is valid.
- `pix_ready_i`  in  1  frame buffer accepts the pixel.
- `x_o`  out  `WIDTH_BITS`  pixel x coordinate.
- `y_o`  out  `HEIGHT_BITS`  pixel y coordinate.
- `r_o`, `g_o`, `b_o`  out  `CHANNEL_BITS`  pixel colour.

## Operation

Opcodes:
- `OP_PIXEL` = 4'h1: a single pixel at (x1, y1).
- `OP_RECT` = 4'h2: a filled rectangle.
- Any other opcode is popped and discarded: no pixels and no `done_o`.

Rectangle bounds are normalised at load:
- xmin = min(x1, x2), xmax = max(x1, x2).
- ymin = min(y1, y2), ymax = max(y1, y2).
- Degenerate rectangles (x1 = x2 and/or y1 = y2) are legal and yield a line or a single pixel.

Walk order is raster order: x is the inner loop from xmin to xmax, y is the outer loop from ymin to ymax.

FIFO:
- A push is accepted iff `push_i` && !`full_o`. `full_o` is the pre-edge value, so a push while full is dropped even if a pop happens in the same cycle.
- A dropped push sets `overflow_o`, which clears only on reset.

FSM states are IDLE, LOAD and EMIT.
- IDLE: if the FIFO is non-empty, pop the head into the working registers and go to LOAD. Otherwise stay in IDLE.
- LOAD: latch the normalised bounds, set cur_x = xmin and cur_y = ymin, and latch the colour.
  - For an unknown opcode, return to IDLE.
  - Otherwise go to EMIT.
- EMIT: `pix_valid_o` = 1. On handshake (`pix_valid_o` && `pix_ready_i`):
  - If cur_x < xmax: cur_x++.
  - Else if cur_y < ymax: cur_x = xmin, cur_y++.
  - Else: pulse `done_o` and go to IDLE.
- Counters are exactly coordinate width; no wrap occurs because bounds are clamped to the coordinate range by construction.

Output rules:
- While `pix_valid_o` && !`pix_ready_i`, `x_o`, `y_o`, `r_o`, `g_o` and `b_o` are held stable.
- When `pix_valid_o` = 0, the pixel outputs hold their last value.

## Timing

- Reset values: all outputs 0, FIFO empty, state IDLE. Reset mid-walk abandons the current primitive and flushes the FIFO; no `done_o` is issued.
- Latency: a push sampled at edge 0 into an empty, idle block is popped at edge 1 and reaches EMIT at edge 2. `pix_valid_o` is high from edge 2.
- Throughput: 1 pixel/cycle while `pix_ready_i` = 1.
- Inter-instruction bubble: 2 cycles of `pix_valid_o` = 0 between the last pixel of one instruction and the first pixel of the next.
- `done_o` is asserted in the cycle after the final handshake edge, i.e. while the FSM is in IDLE, for exactly one cycle.
- `pix_ready_i` may toggle arbitrarily. `pix_valid_o` never drops without a handshake.

## Structure

- Add to `gpu_definitions.vh`: `OP_PIXEL`, `OP_RECT` and the FSM state encodings. Width macros already live there.
- Sub-module `gpu_instr_fifo`: synchronous FIFO storing {opcode, x1, y1, x2, y2, r, g, b}, depth `FIFO_DEPTH`, with `full` and `empty` flags.
- Remainder: FSM, bound normalisation and walk counters in `gpu_draw_sequencer`.

## Test plan

- Single pixel: push `OP_PIXEL` (5,7), rgb (0x1F,0,0), `pix_ready_i` = 1 → exactly one pixel (5,7) at edge 2; `done_o` 1 cycle later; `busy_o` then low.
- Swapped rectangle: push `OP_RECT` x1=3, y1=2, x2=1, y2=1 → 6 pixels: (1,1)(2,1)(3,1)(1,2)(2,2)(3,2); one `done_o`.
- Backpressure: 2×2 rect with `pix_ready_i` toggling 1,0,0,1,… → outputs stable while stalled; 4 handshakes total; order unchanged.
- FIFO full/overflow with `FIFO_DEPTH` = 4 and `pix_ready_i` = 0:
  - Push 6 instructions → the first is popped into EMIT, 4 sit in the FIFO, and `full_o` = 1.
  - The 6th push is dropped and `overflow_o` = 1 sticky.
- Unknown opcode and back-to-back:
  - Push 4'hF, then `OP_PIXEL` (0,0) → no pixel for 4'hF.
  - The pixel appears; 2-cycle gap rule holds between consecutive `OP_PIXEL` instructions.
- Reset mid-walk: assert `n_rst` = 0 during a 4×4 rect at pixel 5 → next edge: outputs 0, FIFO empty, IDLE, no `done_o`.
